player_health_tracker: RTL and testbench

//  Tracks player lives for the game-logic layer. Generalises single-source hit handling to
//  NUM_SRC hit sources, configurable max health, post-hit invulnerability window, heal

---
 rtl/game_pkg.sv | 12 +
 rtl/pulse_edge_detect.sv | 20 ++
 rtl/player_health_tracker.sv | 122 ++++++++++++
 tb/tb_player_health_tracker.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-logic types and defaults used by the health tracker and its neighbours.
package game_pkg;

    typedef enum logic [1:0] {
        HS_ALIVE,
        HS_INVULN,
        HS_DEAD
    } health_state_t;

    localparam int DEFAULT_MAX_HEALTH = 3;

endpackage

// File: rtl/pulse_edge_detect.sv
// Rising-edge detector: registers the previous level of each line and flags 0->1 transitions.
module pulse_edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sig_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) sig_d <= '0;
        else         sig_d <= sig;
    end

    assign rise = sig & ~sig_d;

endmodule

// File: rtl/player_health_tracker.sv
// Player lives tracker: multi-source hit detection, post-hit immunity window, heals,
// and a sticky dead state released only by a new game.
//
//   state     | meaning
//   HS_ALIVE  | vulnerable; hits cost one life, heals add one
//   HS_INVULN | immune to hits for INVULN_CYCLES cycles after a hit
//   HS_DEAD   | out of lives; waits for newGame
module player_health_tracker
    import game_pkg::*;
#(
    parameter int MAX_HEALTH    = DEFAULT_MAX_HEALTH,
    parameter int NUM_SRC       = 3,
    parameter int INVULN_CYCLES = 50,
    parameter int HEALTH_W      = $clog2(MAX_HEALTH + 1)
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic [NUM_SRC-1:0]  hitSrc,
    input  logic                killInstant,
    input  logic                healPulse,
    input  logic                godMode,
    input  logic                newGame,
    output logic [HEALTH_W-1:0] health,
    output logic                lost,
    output logic                invulnerable,
    output logic                hitPulse
);

    localparam int CNT_W = (INVULN_CYCLES > 0) ? $clog2(INVULN_CYCLES + 1) : 1;
    localparam logic [HEALTH_W-1:0] HEALTH_FULL = HEALTH_W'(MAX_HEALTH);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((INVULN_CYCLES > 0) ? (INVULN_CYCLES - 1) : 0);

    health_state_t       state;
    logic [CNT_W-1:0]    cnt;
    logic [NUM_SRC-1:0]  rise;
    logic                hit_ok;
    logic [HEALTH_W-1:0] hit_health;
    logic [HEALTH_W-1:0] heal_health;

    pulse_edge_detect #(.WIDTH(NUM_SRC)) u_hit_edge (
        .clk    (clk),
        .resetN (resetN),
        .sig    (hitSrc),
        .rise   (rise)
    );

    assign hit_ok = (|rise) & ~godMode & (state == HS_ALIVE);

    // A heal landing with a hit cancels it; health is >=1 whenever ALIVE.
    always_comb begin
        hit_health  = healPulse ? health : (health - 1'b1);
        heal_health = (health >= HEALTH_FULL) ? HEALTH_FULL : (health + 1'b1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= HS_ALIVE;
            health       <= HEALTH_FULL;
            cnt          <= '0;
            lost         <= 1'b0;
            invulnerable <= 1'b0;
            hitPulse     <= 1'b0;
        end else begin
            hitPulse <= 1'b0;
            case (state)
                HS_ALIVE: begin
                    if (killInstant) begin
                        state  <= HS_DEAD;
                        health <= '0;
                        lost   <= 1'b1;
                    end else if (hit_ok) begin
                        health   <= hit_health;
                        hitPulse <= 1'b1;
                        if (hit_health == '0) begin
                            state <= HS_DEAD;
                            lost  <= 1'b1;
                        end else if (INVULN_CYCLES > 0) begin
                            state        <= HS_INVULN;
                            cnt          <= CNT_LOAD;
                            invulnerable <= 1'b1;
                        end
                    end else if (healPulse) begin
                        health <= heal_health;
                    end
                end
                HS_INVULN: begin
                    if (killInstant) begin
                        state        <= HS_DEAD;
                        health       <= '0;
                        lost         <= 1'b1;
                        invulnerable <= 1'b0;
                    end else begin
                        if (healPulse) health <= heal_health;
                        if (cnt == '0) begin
                            state        <= HS_ALIVE;
                            invulnerable <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                HS_DEAD: begin
                    if (newGame) begin
                        state  <= HS_ALIVE;
                        health <= HEALTH_FULL;
                        cnt    <= '0;
                        lost   <= 1'b0;
                    end
                end
                default: begin
                    state        <= HS_ALIVE;
                    health       <= HEALTH_FULL;
                    cnt          <= '0;
                    lost         <= 1'b0;
                    invulnerable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_player_health_tracker.sv
// Directed bench: stimulus queues hand-computed expectations tagged by cycle; a negedge
// monitor compares them against either the default build or a zero-window build.
module tb_player_health_tracker;

    typedef struct {
        int         cyc;
        int         which;
        string      name;
        logic [1:0] h;
        logic       l;
        logic       i;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic [2:0] hitSrc = '0;
    logic       killInstant = 1'b0;
    logic       healPulse = 1'b0;
    logic       godMode = 1'b0;
    logic       newGame = 1'b0;
    logic [2:0] hitSrc0 = '0;

    logic [1:0] health,  health0;
    logic       lost,    lost0;
    logic       invulnerable, invulnerable0;
    logic       hitPulse, hitPulse0;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    player_health_tracker dut (
        .clk          (clk),
        .resetN       (resetN),
        .hitSrc       (hitSrc),
        .killInstant  (killInstant),
        .healPulse    (healPulse),
        .godMode      (godMode),
        .newGame      (newGame),
        .health       (health),
        .lost         (lost),
        .invulnerable (invulnerable),
        .hitPulse     (hitPulse)
    );

    player_health_tracker #(.INVULN_CYCLES(0)) dut0 (
        .clk          (clk),
        .resetN       (resetN),
        .hitSrc       (hitSrc0),
        .killInstant  (1'b0),
        .healPulse    (1'b0),
        .godMode      (1'b0),
        .newGame      (1'b0),
        .health       (health0),
        .lost         (lost0),
        .invulnerable (invulnerable0),
        .hitPulse     (hitPulse0)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Expect the given outputs k edges from now (k=0: at the coming negedge).
    task automatic expect_at(input int k, input int which, input string name,
                             input logic [1:0] h, input logic l, input logic i, input logic p);
        exp_t e;
        e.cyc = cyc + k; e.which = which; e.name = name;
        e.h = h; e.l = l; e.i = i; e.p = p;
        sb.push_back(e);
    endtask

    task automatic do_hit(input logic [2:0] src, input string name,
                          input logic [1:0] h, input logic l, input logic i);
        hitSrc = src;
        expect_at(1, 0, name, h, l, i, 1'b1);
        tick();
        hitSrc = '0;
        repeat (51) tick();
    endtask

    always @(negedge clk) begin
        for (int k = sb.size() - 1; k >= 0; k--) begin
            if (sb[k].cyc == cyc) begin
                logic [1:0] ah;
                logic al, ai, ap;
                if (sb[k].which == 0) begin
                    ah = health;  al = lost;  ai = invulnerable;  ap = hitPulse;
                end else begin
                    ah = health0; al = lost0; ai = invulnerable0; ap = hitPulse0;
                end
                n_vec++;
                if (ah !== sb[k].h || al !== sb[k].l || ai !== sb[k].i || ap !== sb[k].p) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got h=%0d lost=%b inv=%b hp=%b want h=%0d lost=%b inv=%b hp=%b",
                             sb[k].name, cyc, ah, al, ai, ap, sb[k].h, sb[k].l, sb[k].i, sb[k].p);
                end
                sb.delete(k);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        expect_at(0, 0, "reset", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        resetN = 1'b1;
        tick();

        // single source held 5 cycles: one decrement, 50-cycle window
        hitSrc = 3'b001;
        expect_at(1,  0, "t1_hit",      2'd2, 1'b0, 1'b1, 1'b1);
        expect_at(2,  0, "t1_pulse1cy", 2'd2, 1'b0, 1'b1, 1'b0);
        expect_at(50, 0, "t1_win_last", 2'd2, 1'b0, 1'b1, 1'b0);
        expect_at(51, 0, "t1_win_end",  2'd2, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        hitSrc = '0;
        repeat (50) tick();

        // two sources together, a discarded rise in the window, then a fatal hit
        hitSrc = 3'b101;
        expect_at(1, 0, "t2_multi", 2'd1, 1'b0, 1'b1, 1'b1);
        repeat (10) tick();
        hitSrc = 3'b111;
        expect_at(1, 0, "t2_in_win", 2'd1, 1'b0, 1'b1, 1'b0);
        repeat (2) tick();
        hitSrc = '0;
        repeat (40) tick();
        hitSrc = 3'b010;
        expect_at(1, 0, "t2_fatal", 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        hitSrc = '0;
        tick();

        // dead: hit + heal ignored; held source through restart does not hit
        hitSrc = 3'b001; healPulse = 1'b1;
        expect_at(1, 0, "t3_dead_ign", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        healPulse = 1'b0;
        newGame = 1'b1;
        expect_at(1, 0, "t3_newgame", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        newGame = 1'b0;
        expect_at(1, 0, "t3_held_src", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        hitSrc = '0;
        tick();

        // three spaced hits down to zero
        do_hit(3'b001, "t3_hit1", 2'd2, 1'b0, 1'b1);
        do_hit(3'b100, "t3_hit2", 2'd1, 1'b0, 1'b1);
        do_hit(3'b010, "t3_hit3", 2'd0, 1'b1, 1'b0);
        healPulse = 1'b1;
        expect_at(1, 0, "t3_heal_dead", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        healPulse = 1'b0;
        newGame = 1'b1;
        expect_at(1, 0, "t3_restart", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        newGame = 1'b0;
        tick();

        // heal and hit in the same cycle, then saturating heal
        do_hit(3'b001, "t4_to2", 2'd2, 1'b0, 1'b1);
        healPulse = 1'b1; hitSrc = 3'b001;
        expect_at(1, 0, "t4_heal_hit", 2'd2, 1'b0, 1'b1, 1'b1);
        tick();
        healPulse = 1'b0; hitSrc = '0;
        repeat (51) tick();
        healPulse = 1'b1;
        expect_at(1, 0, "t4_heal_up", 2'd3, 1'b0, 1'b0, 1'b0);
        expect_at(2, 0, "t4_heal_sat", 2'd3, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        healPulse = 1'b0;
        tick();

        // god mode blocks hits but not instant kill
        godMode = 1'b1; hitSrc = 3'b010;
        expect_at(1, 0, "t5_god1", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        hitSrc = '0;
        tick();
        hitSrc = 3'b100;
        expect_at(1, 0, "t5_god2", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        killInstant = 1'b1;
        expect_at(1, 0, "t5_kill", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        killInstant = 1'b0; godMode = 1'b0; hitSrc = '0;
        newGame = 1'b1;
        expect_at(1, 0, "t5_restart", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        newGame = 1'b0;
        tick();

        // kill during the invulnerability window
        hitSrc = 3'b001;
        expect_at(1, 0, "tk_hit", 2'd2, 1'b0, 1'b1, 1'b1);
        tick();
        hitSrc = '0;
        repeat (5) tick();
        killInstant = 1'b1;
        expect_at(1, 0, "tk_kill_inv", 2'd0, 1'b1, 1'b0, 1'b0);
        tick();
        killInstant = 1'b0;
        newGame = 1'b1;
        expect_at(1, 0, "tk_restart", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        newGame = 1'b0;
        tick();

        // async reset in the middle of the window (counter at 20)
        hitSrc = 3'b001;
        expect_at(1, 0, "t6_hit", 2'd2, 1'b0, 1'b1, 1'b1);
        tick();
        hitSrc = '0;
        repeat (29) tick();
        expect_at(0, 0, "t6_pre_rst", 2'd2, 1'b0, 1'b1, 1'b0);
        tick();
        resetN = 1'b0;
        expect_at(0, 0, "t6_async_rst", 2'd3, 1'b0, 1'b0, 1'b0);
        tick();
        resetN = 1'b1;
        tick();

        // zero-length window: rises two cycles apart each cost a life
        hitSrc0 = 3'b001;
        expect_at(1, 1, "z_hit1", 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        hitSrc0 = '0;
        expect_at(1, 1, "z_gap", 2'd2, 1'b0, 1'b0, 1'b0);
        tick();
        hitSrc0 = 3'b001;
        expect_at(1, 1, "z_hit2", 2'd1, 1'b0, 1'b0, 1'b1);
        tick();
        hitSrc0 = '0;
        tick();
        hitSrc0 = 3'b001;
        expect_at(1, 1, "z_hit3", 2'd0, 1'b1, 1'b0, 1'b1);
        tick();
        hitSrc0 = '0;
        repeat (3) tick();

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
            n_fail += sb.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
